// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM for the LC-3b instruction fetch path.
// Walks PC->MAR, memory->MDR, MDR->IR, screens the opcode, hands the
// instruction to the execute controller and counts retirements.
// Memory waits are bounded; an illegal opcode or a memory timeout parks
// the FSM in HALT with an error code until reset_n.
module fetch_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             mem_resp,
    input  logic             exec_done,
    output logic             load_pc,
    output logic             pcmux_sel,
    output logic             load_mar,
    output logic             marmux_sel,
    output logic             load_mdr,
    output logic             mdrmux_sel,
    output logic             mem_read,
    output logic             load_ir,
    output logic             exec_start,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH1 = 3'd1;
    localparam logic [2:0] S_FETCH2 = 3'd2;
    localparam logic [2:0] S_FETCH3 = 3'd3;
    localparam logic [2:0] S_DECODE = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    // The wait counter holds (FETCH2 cycle number - 1), so it never needs
    // to reach MEM_TIMEOUT itself.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    logic [2:0]        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [1:0]        err_code_reg, err_code_next;
    logic [CNT_W-1:0]  instr_count_reg, instr_count_next;

    logic illegal_op;
    logic wait_last;

    // RTI (1000) and the reserved 1010/1011 encodings are not executable.
    assign illegal_op = (opcode == 4'b1000) || (opcode == 4'b1010) || (opcode == 4'b1011);
    assign wait_last  = (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1));

    // State, wait counter, error code and retire counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= S_IDLE;
            wait_cnt_reg    <= '0;
            err_code_reg    <= 2'b00;
            instr_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            err_code_reg    <= err_code_next;
            instr_count_reg <= instr_count_next;
        end
    end

    // Next-state logic; err_code only changes on the transition into HALT.
    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        err_code_next    = err_code_reg;
        instr_count_next = instr_count_reg;
        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_FETCH1;
            end
            S_FETCH1: begin
                state_next    = S_FETCH2;
                wait_cnt_next = '0;
            end
            S_FETCH2: begin
                if (mem_resp) begin
                    state_next = S_FETCH3;
                end else if (wait_last) begin
                    state_next    = S_HALT;
                    err_code_next = ERR_TIMEOUT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            S_FETCH3: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                if (illegal_op) begin
                    state_next    = S_HALT;
                    err_code_next = ERR_ILLEGAL;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    instr_count_next = instr_count_reg + CNT_W'(1);
                    state_next       = run ? S_FETCH1 : S_IDLE;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Moore decode of the control outputs from the registered state.
    // load_mdr and exec_start are qualified by their data inputs so MDR
    // only captures valid memory data and illegal opcodes never start.
    always_comb begin
        load_pc    = (state_reg == S_FETCH1);
        pcmux_sel  = (state_reg == S_FETCH1);
        load_mar   = (state_reg == S_FETCH1);
        marmux_sel = (state_reg == S_FETCH1);
        mem_read   = (state_reg == S_FETCH2);
        mdrmux_sel = (state_reg == S_FETCH2);
        load_mdr   = (state_reg == S_FETCH2) && mem_resp;
        load_ir    = (state_reg == S_FETCH3);
        exec_start = (state_reg == S_DECODE) && !illegal_op;
        busy       = (state_reg != S_IDLE) && (state_reg != S_HALT);
        halted     = (state_reg == S_HALT);
    end

    assign err_code    = err_code_reg;
    assign instr_count = instr_count_reg;

endmodule
